// File: rtl/vector_sum_driver.sv
// Serial-to-vector packer that launches the 4-element adder and returns its sum on a stream.
// Optional macro DRV_TIMEOUT_EN adds a bounded wait on adder_finished and a sticky o_err_timeout.
module vector_sum_driver #(
  parameter int unsigned ELEM_W   = 32,
  parameter int unsigned NUM_ELEM = 4,
  parameter int unsigned SUM_W    = 34,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [ELEM_W-1:0]          i_in_data,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  output logic [ELEM_W*NUM_ELEM-1:0] o_adder_vector,
  output logic                       o_adder_enable,
  output logic                       o_adder_clear,
  input  logic                       i_adder_finished,
  input  logic [SUM_W-1:0]           i_adder_sum,
  output logic [SUM_W-1:0]           o_out_sum,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
`ifdef DRV_TIMEOUT_EN
  output logic                       o_err_timeout,
`endif
  output logic                       o_busy
);

  localparam int unsigned VecW = ELEM_W * NUM_ELEM;
  localparam int unsigned CntW = $clog2(NUM_ELEM + 1);

  typedef enum logic [1:0] {StFill, StLaunch, StWait, StOut} state_e;

  state_e               r_state;
  state_e               w_state_next;
  logic [CntW-1:0]      r_count;
  logic [VecW-1:0]      r_vector;
  logic [SUM_W-1:0]     r_out_sum;
  logic                 r_out_valid;
  logic                 r_adder_clear;
  logic                 w_accept;
  logic                 w_finish;
  logic                 w_handshake;
  logic                 w_timeout;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_handshake  = 1'b0;
    unique case (r_state)
      StFill: begin
        w_accept = i_in_valid;
        if (w_accept && (r_count == CntW'(NUM_ELEM - 1))) w_state_next = StLaunch;
      end
      StLaunch: w_state_next = StWait;
      StWait: begin
        // Finished flag seen during LAUNCH is stale and never reaches here.
        w_finish = i_adder_finished;
        if (w_finish || w_timeout) w_state_next = StOut;
      end
      StOut: begin
        w_handshake = i_out_ready;
        if (w_handshake) w_state_next = StFill;
      end
      default: w_state_next = StFill;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= StFill;
      r_count       <= '0;
      r_vector      <= '0;
      r_out_sum     <= '0;
      r_out_valid   <= 1'b0;
      r_adder_clear <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_adder_clear <= w_handshake;
      if (w_accept) begin
        for (int unsigned k = 0; k < NUM_ELEM; k++) begin
          if (r_count == CntW'(k)) r_vector[k*ELEM_W +: ELEM_W] <= i_in_data;
        end
        r_count <= r_count + CntW'(1);
      end
      if (w_finish) begin
        r_out_sum   <= i_adder_sum;
        r_out_valid <= 1'b1;
      end else if (w_timeout) begin
        r_out_sum   <= '0;
        r_out_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_count     <= '0;
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef DRV_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT + 1);

  logic [ToW-1:0] r_wait_cnt;
  logic           r_err_timeout;

  assign w_timeout = (r_state == StWait) && !i_adder_finished &&
                     (r_wait_cnt == ToW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == StWait) ? r_wait_cnt + ToW'(1) : '0;
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  assign o_in_ready     = (r_state == StFill);
  assign o_adder_enable = (r_state == StLaunch);
  assign o_adder_clear  = r_adder_clear;
  assign o_adder_vector = r_vector;
  assign o_out_sum      = r_out_sum;
  assign o_out_valid    = r_out_valid;
  assign o_busy         = !((r_state == StFill) && (r_count == '0));

endmodule

// File: doc/vector_sum_driver.md
Name: vector_sum_driver

Overview:
- Initiator-side companion to the 4-element pipelined vector adder.
- Accepts 32-bit elements serially on a valid/ready stream and packs four of them into a 128-bit vector.
- Launches the adder, waits for its finished flag, and captures the 34-bit sum.
- Presents the sum on a valid/ready output stream, then clears the adder for the next vector. Sits between the matrix-row fetch logic and the adder in the multiply engine.

Parameters:
- ELEM_W, 32, width of one input element
- NUM_ELEM, 4, elements per vector; fixed at 4, matches the adder
- SUM_W, 34, width of the adder sum and of the output result
- TIMEOUT, 15, max cycles to wait for adder finished; used only with the optional feature

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-low reset
- in_data  in  32  input element
- in_valid  in  1  in_data is valid
- in_ready  out  1  driver accepts an element this cycle
- adder_vector  out  128  packed vector to adder; element k at bits [32k+31:32k]
- adder_enable  out  1  one-cycle launch pulse to adder
- adder_clear  out  1  one-cycle pulse that returns the adder to idle
- adder_finished  in  1  adder sum is valid
- adder_sum  in  34  adder result
- out_sum  out  34  captured sum
- out_valid  out  1  out_sum is valid
- out_ready  in  1  consumer accepts out_sum
- busy  out  1  high in every state except FILL with slot count 0

Behaviour:
- Reset (Reset==0 at a clock edge) forces:
  - state FILL, slot count 0
  - adder_vector=0, out_sum=0
  - in_ready=1 (comb. in FILL), out_valid=0, adder_enable=0, adder_clear=0, busy=0
- Reset mid-operation abandons any partial vector or pending result.
- States:
  - FILL: in_ready=1. Each in_valid&&in_ready edge writes in_data into slot[count], then count++. On the 4th accept, go to LAUNCH. Gaps in in_valid are allowed and stall only.
  - LAUNCH: in_ready=0, adder_enable=1 for exactly one cycle, then go to WAIT. adder_vector is stable from the 4th accept until leaving OUT.
  - WAIT: in_ready=0. On adder_finished==1, register out_sum<=adder_sum, set out_valid=1, go to OUT. adder_finished asserted in the LAUNCH cycle is ignored as stale.
  - OUT: out_valid=1 and out_sum held until out_ready. On the handshake edge, out_valid<=0, adder_clear pulses 1 cycle, count<=0, go to FILL.
- In the cycle after the handshake, FILL accepts immediately. There is no overlap: a new vector is never accepted while a result is pending.
- Latency: 4th accept at edge N → adder_enable high in cycle N+1. Result at out_valid one cycle after the adder_finished edge.
- Arithmetic: none internal. The sum is passed through unmodified at SUM_W bits; no truncation.
- out_valid must not drop without out_ready. in_ready is a function of state only, with no in_valid→in_ready combinational path.

Optional Feature:
- Macro DRV_TIMEOUT_EN.
- With it:
  - A counter runs in WAIT. If adder_finished has not arrived after TIMEOUT cycles, out_sum<=0, out_valid=1, and a sticky extra output err_timeout=1 is set.
  - The driver then proceeds as for OUT.
  - err_timeout clears only on reset.
- Without it: the err_timeout port is absent and WAIT waits indefinitely.

Test Plan:
- Reset, then elements 1,2,3,4 back-to-back → adder_vector=0x00000004_00000003_00000002_00000001, one adder_enable pulse; model finishes with 10 → out_sum=10, out_valid=1.
- Elements 0xFFFFFFFF ×4, model sum 0x3FFFFFFFC → out_sum=34'h3FFFFFFFC, no truncation.
- in_valid toggling every other cycle with 5,6,7,8 → exactly 4 accepts, launch after the 4th; out_ready held low 10 cycles → out_sum=26 held steady, in_ready=0 throughout; on release, adder_clear pulses once and in_ready=1 next cycle.
- Reset driven low in WAIT after 2 cycles → all outputs return to reset values; later finished pulse is ignored, with no out_valid.
- Two consecutive vectors (1..4, then 10,20,30,40) with out_ready=1 → results 10 then 100, in order, one enable and one clear each.
- DRV_TIMEOUT_EN defined, adder model never finishes → after 15 WAIT cycles out_valid=1, out_sum=0, err_timeout=1 sticky until reset.
